// File: rtl/ej32_div.sv
// ----------------------------------------------------------------------------
// ej32_div
//   Multi-cycle signed integer divider for the eJ32 arithmetic unit
//   (idiv / irem).
//   Algorithm: restoring shift-subtract on operand magnitudes, one quotient
//   bit per clock. Signs are applied at the end, so results truncate toward
//   zero (Java semantics).
//
// Handshake:
//   - While idle, div_en is sampled on a rising edge. If it is high, that
//     edge is the start edge and dvd/dvs are latched.
//   - div_bsy is a flop. It rises after the start edge and stays high for
//     exactly DSZ+1 cycles.
//   - div_done pulses for one cycle on the first cycle that div_bsy is low.
//     div_q, div_r and div_dz become valid in that cycle and hold until the
//     next completion.
//   - div_en is ignored while an operation is running.
//   - div_en asserted in the div_done cycle starts the next operation.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   div_en    start request (sampled only while idle)
//   dvd       dividend (NOS), signed
//   dvs       divisor  (TOS), signed
//   div_bsy   operation in progress
//   div_done  one-cycle completion pulse
//   div_q     quotient, signed
//   div_r     remainder, signed
//   div_dz    last completed operation was a divide by zero
//   dbg_state current FSM state, for observation only
// ----------------------------------------------------------------------------
module ej32_div #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           div_en,
    input  logic [DSZ-1:0] dvd,
    input  logic [DSZ-1:0] dvs,
    output logic           div_bsy,
    output logic           div_done,
    output logic [DSZ-1:0] div_q,
    output logic [DSZ-1:0] div_r,
    output logic           div_dz,
    output logic [1:0]     dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int CW = $clog2(DSZ);
    localparam logic [CW-1:0] CNT_LAST = CW'(DSZ - 1);

    logic [1:0]     state;
    logic [CW-1:0]  count;
    logic [DSZ-1:0] quo;        // dividend magnitude shifting out, quotient shifting in
    logic [DSZ-1:0] dvs_mag;
    logic [DSZ-1:0] rem;        // partial remainder, always < divisor magnitude (or <= |dvd| when dz)
    logic           sign_q;
    logic           sign_r;
    logic           dz;

    logic [DSZ-1:0] dvd_mag_in;
    logic [DSZ-1:0] dvs_mag_in;
    logic [DSZ:0]   rem_sh;
    logic [DSZ:0]   trial;
    logic           trial_ok;
    logic [DSZ-1:0] q_fix;
    logic [DSZ-1:0] r_fix;

    // Negating the most-negative value wraps back to 0x80..0.
    // Read as unsigned, that is 2^(DSZ-1), which is the correct magnitude.
    assign dvd_mag_in = dvd[DSZ-1] ? -dvd : dvd;
    assign dvs_mag_in = dvs[DSZ-1] ? -dvs : dvs;

    // The shifted remainder needs one extra bit, because it can reach 2^DSZ-1.
    assign rem_sh   = {rem, quo[DSZ-1]};
    assign trial    = rem_sh - {1'b0, dvs_mag};
    assign trial_ok = ~trial[DSZ];

    // With a zero divisor every trial succeeds, so the remainder ends up
    // equal to |dvd|. After sign correction it equals the raw dividend.
    // Only the quotient needs forcing to all ones.
    assign q_fix = dz ? '1 : (sign_q ? -quo : quo);
    assign r_fix = sign_r ? -rem : rem;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            count    <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            rem      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz       <= 1'b0;
            div_bsy  <= 1'b0;
            div_done <= 1'b0;
            div_q    <= '0;
            div_r    <= '0;
            div_dz   <= 1'b0;
        end else begin
            div_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (div_en) begin
                        quo     <= dvd_mag_in;
                        dvs_mag <= dvs_mag_in;
                        rem     <= '0;
                        sign_q  <= dvd[DSZ-1] ^ dvs[DSZ-1];
                        sign_r  <= dvd[DSZ-1];
                        dz      <= (dvs == '0);
                        count   <= CNT_LAST;
                        div_bsy <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem   <= trial_ok ? trial[DSZ-1:0] : rem_sh[DSZ-1:0];
                    quo   <= {quo[DSZ-2:0], trial_ok};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    div_q    <= q_fix;
                    div_r    <= r_fix;
                    div_dz   <= dz;
                    div_bsy  <= 1'b0;
                    div_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_div.sv
// ----------------------------------------------------------------------------
// tb_ej32_div
//   Self-checking bench for ej32_div. Directed cases plus random operands are
//   compared against a signed 64-bit arithmetic model of Java idiv/irem.
// ----------------------------------------------------------------------------
module tb_ej32_div;

    localparam int DSZ = 32;
    localparam int LAT = DSZ + 1;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic           div_en;
    logic [DSZ-1:0] dvd;
    logic [DSZ-1:0] dvs;
    logic           div_bsy;
    logic           div_done;
    logic [DSZ-1:0] div_q;
    logic [DSZ-1:0] div_r;
    logic           div_dz;
    logic [1:0]     dbg_state;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ej32_div #(.DSZ(DSZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_en    (div_en),
        .dvd       (dvd),
        .dvs       (dvs),
        .div_bsy   (div_bsy),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_dz    (div_dz),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            // 64-bit division truncates toward zero.
            // MIN / -1 gives +2^31, which wraps to 0x80000000 when truncated to 32 bits.
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Present operands for one rising edge, then scramble them.
    // The inputs must not matter after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dvd    = a;
        dvs    = b;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
        dvd    = $urandom;
        dvs    = $urandom;
    endtask

    // Count cycles with div_bsy high, bounded.
    // Also counts any done pulse seen while busy.
    task automatic wait_idle(output int cyc, output int early);
        cyc   = 0;
        early = 0;
        while (div_bsy === 1'b1 && cyc < 200) begin
            cyc++;
            if (div_done !== 1'b0) early++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b0;
        div_en = 1'b0;
        dvd    = '0;
        dvs    = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({div_bsy, div_done, div_q, div_r, div_dz} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got bsy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     div_bsy, div_done, div_q, div_r, div_dz);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (div_bsy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got bsy=%b done=%b, want 0 0", div_bsy, div_done);
        end
    endtask

    task automatic test_basic();
        int cyc, early;
        logic [31:0] q_held;
        start_op(32'd100, 32'd7);
        checks++;
        if (div_bsy !== 1'b1) begin
            errors++;
            $display("FAIL bsy_after_start: got %b want 1", div_bsy);
        end
        wait_idle(cyc, early);
        checks++;
        if (cyc != LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", cyc, LAT);
        end
        checks++;
        if (div_done !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL basic_done: got done=%b early=%0d want done=1 early=0", div_done, early);
        end
        checks++;
        if (div_q !== 32'd14 || div_r !== 32'd2 || div_dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%h r=%h dz=%b want q=0000000e r=00000002 dz=0",
                     div_q, div_r, div_dz);
        end
        q_held = div_q;
        @(negedge clk);
        checks++;
        if (div_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", div_done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (div_q !== 32'd14 || q_held !== 32'd14) begin
            errors++;
            $display("FAIL basic_hold: got q=%h want 0000000e", div_q);
        end
    endtask

    // Sign combinations and edge values, driven from a compact table.
    task automatic test_signs_edges();
        logic [31:0] ta [9];
        logic [31:0] tb [9];
        logic [31:0] eq, er;
        logic        edz;
        int cyc, early;
        ta = '{32'd100, -32'sd100, 32'd100, -32'sd100, MIN, MIN, 32'd7, 32'd0, 32'd0};
        tb = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'hFFFF_FFFF, 32'd1, 32'd100, 32'd5, -32'sd5};
        for (int i = 0; i < 9; i++) begin
            ref_div(ta[i], tb[i], eq, er, edz);
            start_op(ta[i], tb[i]);
            wait_idle(cyc, early);
            checks++;
            if (cyc != LAT || div_done !== 1'b1) begin
                errors++;
                $display("FAIL table_timing[%0d]: got cyc=%0d done=%b want %0d 1", i, cyc, div_done, LAT);
            end
            checks++;
            if (div_q !== eq || div_r !== er || div_dz !== edz) begin
                errors++;
                $display("FAIL table_result[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], div_q, div_r, div_dz, eq, er, edz);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc, early;
        start_op(32'd1234, 32'd0);
        wait_idle(cyc, early);
        checks++;
        if (cyc != LAT || div_done !== 1'b1) begin
            errors++;
            $display("FAIL dz_timing: got cyc=%0d done=%b want %0d 1", cyc, div_done, LAT);
        end
        checks++;
        if (div_q !== 32'hFFFF_FFFF || div_r !== 32'd1234 || div_dz !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b want q=ffffffff r=000004d2 dz=1",
                     div_q, div_r, div_dz);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (div_dz !== 1'b1) begin
            errors++;
            $display("FAIL dz_sticky: got dz=%b want 1", div_dz);
        end
        start_op(32'd9, 32'd3);
        wait_idle(cyc, early);
        checks++;
        if (div_q !== 32'd3 || div_r !== 32'd0 || div_dz !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got q=%h r=%h dz=%b want q=00000003 r=00000000 dz=0",
                     div_q, div_r, div_dz);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        logic        edz;
        int cyc, early;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = 32'($signed($urandom_range(0, 40)) - 20); end
                2: begin a = 32'($signed($urandom_range(0, 2000)) - 1000); b = $urandom_range(1, 50); end
                default: begin a = $urandom; b = ($urandom_range(0, 1) != 0) ? MIN : 32'hFFFF_FFFF; end
            endcase
            ref_div(a, b, eq, er, edz);
            start_op(a, b);
            wait_idle(cyc, early);
            checks++;
            if (cyc != LAT || div_done !== 1'b1 || div_q !== eq || div_r !== er || div_dz !== edz) begin
                errors++;
                $display("FAIL random[%0d] %h/%h: got cyc=%0d done=%b q=%h r=%h dz=%b want cyc=%0d done=1 q=%h r=%h dz=%b",
                         i, a, b, cyc, div_done, div_q, div_r, div_dz, LAT, eq, er, edz);
            end
        end
    endtask

    // A start request while busy is ignored.
    // A start request in the done cycle launches the next operation.
    task automatic test_busy_collision();
        int cyc, early;
        start_op(32'd50, 32'd5);
        repeat (9) @(negedge clk);
        dvd    = 32'd1;
        dvs    = 32'd1;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
        wait_idle(cyc, early);
        checks++;
        if (cyc != LAT - 10 || div_done !== 1'b1) begin
            errors++;
            $display("FAIL collide_timing: got remaining cyc=%0d done=%b want %0d 1", cyc, div_done, LAT - 10);
        end
        checks++;
        if (div_q !== 32'd10 || div_r !== 32'd0) begin
            errors++;
            $display("FAIL collide_result: got q=%h r=%h want q=0000000a r=00000000", div_q, div_r);
        end
        // back-to-back: request in the done cycle
        dvd    = 32'd81;
        dvs    = -32'sd9;
        div_en = 1'b1;
        @(negedge clk);
        div_en = 1'b0;
        checks++;
        if (div_bsy !== 1'b1 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: got bsy=%b done=%b want 1 0", div_bsy, div_done);
        end
        wait_idle(cyc, early);
        checks++;
        if (cyc != LAT || div_q !== 32'hFFFF_FFF7 || div_r !== 32'd0) begin
            errors++;
            $display("FAIL b2b_result: got cyc=%0d q=%h r=%h want cyc=%0d q=fffffff7 r=00000000",
                     cyc, div_q, div_r, LAT);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, early, dones;
        start_op(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({div_bsy, div_done, div_q, div_r, div_dz} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got bsy=%b done=%b q=%h r=%h dz=%b want all zero",
                     div_bsy, div_done, div_q, div_r, div_dz);
        end
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_done !== 1'b0 || div_bsy !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d busy/done cycles after abort, want 0", dones);
        end
        start_op(32'd81, 32'd9);
        wait_idle(cyc, early);
        checks++;
        if (cyc != LAT || div_done !== 1'b1 || div_q !== 32'd9 || div_r !== 32'd0) begin
            errors++;
            $display("FAIL midop_fresh: got cyc=%0d done=%b q=%h r=%h want cyc=%0d done=1 q=00000009 r=00000000",
                     cyc, div_done, div_q, div_r, LAT);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_signs_edges();
        test_div_zero();
        test_random();
        test_busy_collision();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ej32_div.md
Name: ej32_div

Overview:
- Multi-cycle signed integer divider that services the idiv/irem requests of the eJ32 arithmetic unit.
- The arithmetic unit launches a divide with NOS as dividend and TOS as divisor.
- It then stalls while div_bsy is high, and consumes the quotient or remainder from this block.
- Restoring shift-subtract, one quotient bit per clock, Java truncating semantics.

Parameters:
- DSZ, 32, operand/result width in bits (data unit width of the stack).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low.
- div_en  input  1  start request; sampled only while idle.
- dvd  input  DSZ  dividend (NOS, s), signed two's complement.
- dvs  input  DSZ  divisor (TOS, t), signed two's complement.
- div_bsy  output  1  high while a divide is in progress.
- div_done  output  1  one-cycle pulse when results become valid.
- div_q  output  DSZ  quotient, signed.
- div_r  output  DSZ  remainder, signed.
- div_dz  output  1  sticky divide-by-zero flag for the last operation.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; div_bsy=0, div_done=0, div_q=0, div_r=0, div_dz=0; internal count, accumulators cleared. Reset mid-operation aborts it; no done pulse follows.
- States:
  - IDLE: wait for start.
  - CALC: DSZ iterations.
  - FIX: apply sign correction and write the outputs.
- IDLE -> CALC on rising edge with div_en=1. At that edge:
  - Latch |dvd| into quotient shift register, |dvs| into divisor register.
  - Clear partial remainder (DSZ+1 bits).
  - Record sign_q = dvd[MSB]^dvs[MSB] and sign_r = dvd[MSB].
  - Record dz = (dvs==0).
  - Set count = DSZ-1.
  - div_bsy goes 1 after this edge (registered).
- CALC, each cycle:
  - Shift {rem,quo} left by 1.
  - Trial = rem - divisor.
  - If trial is non-negative: rem = trial, quo LSB = 1; else quo LSB = 0.
  - Decrement count; after count==0 iteration go to FIX.
- FIX, one cycle:
  - div_q = sign_q ? -quo : quo.
  - div_r = sign_r ? -rem : rem.
  - div_dz = dz.
  - div_bsy -> 0 and div_done -> 1 at the FIX->IDLE edge.
- Latency: div_bsy high for exactly DSZ+1 cycles (33 for DSZ=32), counted from the edge after the start edge. Results valid on the first cycle div_bsy is low and held until the next completion.
- Handshake: the arithmetic unit asserts div_en in phase 0. In phase 1 it must see div_bsy=1 and wait for it to fall before DROP. div_bsy is therefore a flop, never combinational from div_en.
- div_en while div_bsy=1 or in FIX: ignored, no effect on the running operation.
- div_en in the same cycle that div_done pulses (state IDLE) starts a new operation; back-to-back is legal.
- Absolute value of most-negative operand (0x80000000): treated as unsigned 2^31 in the magnitude path; no overflow inside CALC.
- Overflow case MIN / -1: result div_q=0x80000000, div_r=0 (Java wraparound), div_dz=0.
- Divide by zero: still runs full latency. Result div_q=0xFFFFFFFF, div_r=dvd (raw dividend), div_dz=1. div_dz is cleared by the next completed non-zero divide.
- Dividend 0: q=0, r=0 regardless of divisor sign (no negative zero issue).
- Inputs dvd/dvs are only sampled at the start edge; later changes are don't-care.

Test Plan:
- 100/7, div_en one cycle -> div_bsy high 33 cycles, then div_q=14, div_r=2, div_done single pulse, div_dz=0.
- Signs: -100/7 -> q=-14 (0xFFFFFFF2), r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
- Edge values:
  - 0x80000000 / -1 -> q=0x80000000, r=0.
  - 0x80000000 / 1 -> q=0x80000000, r=0.
  - 7/100 -> q=0, r=7.
- Divide by zero: 1234/0 -> after 33 cycles q=0xFFFFFFFF, r=1234, div_dz=1; then 9/3 -> q=3, r=0, div_dz=0.
- Busy collision: 50/5 started, div_en pulsed with 1/1 at cycle 10 -> ignored, result q=10 r=0. A second div_en on the done cycle starts a new op, and div_bsy is high the next cycle.
- Reset mid-op: rst low at cycle 15 of CALC -> all outputs 0 immediately, no div_done. A fresh 81/9 after release gives q=9, r=0.
